life_grid_scanner: RTL and testbench

Display-side consumer of the 64-bit Game of Life grid produced by the generation FSM. It accepts a grid snapshot over a valid/ready handshake into a shadow buffer, promotes it at frame boundaries (no tearing), and scans the active grid onto an 8x8 LED matrix one row at a time. Each row is lit for a dwell period, with a blanking gap before every row. Sits between the evolve FSM output and the board's matrix pins.

---
 rtl/life_pkg.sv | 23 ++
 rtl/life_period_timer.sv | 32 +++
 rtl/life_grid_scanner.sv | 148 ++++++++++++++
 tb/tb_life_grid_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life blocks (evolve FSM, datapath, display scanner).
// Contents:
//   GRID_N       - grid edge length (rows and columns)
//   GRID_W       - total grid bits, bit 8*r+c = row r, column c
//   scan_state_t - display scanner states
//   row_slice    - extracts the 8 column bits of one row from a grid word
package life_pkg;

    localparam int unsigned GRID_N = 8;
    localparam int unsigned GRID_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    function automatic logic [GRID_N-1:0] row_slice(input logic [GRID_W-1:0] grid,
                                                    input logic [2:0]        row);
        return grid[row*GRID_N +: GRID_N];
    endfunction

endpackage

// File: rtl/life_period_timer.sv
// Loadable period counter used for both the blanking gap and the row dwell.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, clears the count
//   load  - restart the period (count <= 0); wins over hold
//   hold  - freeze the count
//   last  - final count of the period (period length - 1)
//   tc    - terminal count: high while count == last
module life_period_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             hold,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count_q <= '0;
        end else if (!hold) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == last);

endmodule

// File: rtl/life_grid_scanner.sv
// Double-buffered 8x8 LED matrix scanner for the Game of Life grid.
// A snapshot is accepted into a shadow buffer over valid/ready and promoted to the
// displayed grid only at a frame boundary, so a frame never mixes two generations.
// Each row is preceded by BLANK_CYCLES of all-off, then driven for DWELL_CYCLES.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   enable       - 1 runs the scan; 0 freezes the scan position and blanks the outputs
//   grid_in      - grid snapshot, bit 8*r+c = row r, column c
//   grid_valid   - grid_in valid this cycle
//   grid_ready   - shadow buffer empty; transfer when valid && ready at posedge
//   row_sel      - one-hot row drive, 0 while blanking/idle
//   col_data     - column data of the driven row, 0 otherwise
//   frame_done   - pulse on the last dwell cycle of row 7
//   frame_count  - completed frames, wrapping
module life_grid_scanner import life_pkg::*; #(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned FCNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [GRID_W-1:0] grid_in,
    input  logic              grid_valid,
    output logic              grid_ready,
    output logic [GRID_N-1:0] row_sel,
    output logic [GRID_N-1:0] col_data,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    LAST_ROW   = 3'(GRID_N - 1);

    scan_state_t       state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [GRID_W-1:0] active_q, active_d;
    logic [GRID_W-1:0] shadow_q;
    logic              shadow_full_q, shadow_full_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;

    logic              timer_load;
    logic [TW-1:0]     timer_last;
    logic              timer_tc;
    logic              accept;

    assign grid_ready  = !shadow_full_q && !reset;
    assign accept      = grid_valid && grid_ready;
    assign frame_count = frame_count_q;

    life_period_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .hold  (!enable),
        .last  (timer_last),
        .tc    (timer_tc)
    );

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        active_d      = active_q;
        shadow_full_d = shadow_full_q;
        frame_count_d = frame_count_q;
        timer_load    = 1'b0;
        timer_last    = BLANK_LAST;
        row_sel       = '0;
        col_data      = '0;
        frame_done    = 1'b0;

        case (state_q)
            IDLE: begin
                // Timer kept cleared so the first blank period starts from zero.
                // Promotion out of IDLE does not wait for enable.
                timer_load = 1'b1;
                if (shadow_full_q) begin
                    active_d      = shadow_q;
                    shadow_full_d = 1'b0;
                    row_d         = '0;
                    state_d       = BLANK;
                end
            end
            BLANK: begin
                timer_last = BLANK_LAST;
                if (enable && timer_tc) begin
                    timer_load = 1'b1;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                timer_last = DWELL_LAST;
                if (enable) begin
                    row_sel  = {{(GRID_N-1){1'b0}}, 1'b1} << row_q;
                    col_data = row_slice(active_q, row_q);
                    if (timer_tc) begin
                        timer_load = 1'b1;
                        state_d    = BLANK;
                        row_d      = row_q + 3'd1;  // 7 wraps to 0
                        if (row_q == LAST_ROW) begin
                            frame_done    = 1'b1;
                            frame_count_d = frame_count_q + 1'b1;
                            // Only frame boundary where a waiting grid is promoted.
                            if (shadow_full_q) begin
                                active_d      = shadow_q;
                                shadow_full_d = 1'b0;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept needs an empty shadow, so it never coincides with a promotion.
        if (accept) begin
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            active_q      <= active_d;
            shadow_full_q <= shadow_full_d;
            frame_count_q <= frame_count_d;
            if (accept) begin
                shadow_q <= grid_in;
            end
        end
    end

endmodule

// File: tb/tb_life_grid_scanner.sv
module tb_life_grid_scanner;

    localparam int BL      = 2;
    localparam int DW      = 3;
    localparam int FW      = 4;
    localparam int ROW_T   = BL + DW;
    localparam int FRAME_T = 8 * ROW_T;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [63:0] grid_in = '0;
    logic        grid_valid = 1'b0;
    logic        grid_ready;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic [FW-1:0] frame_count;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int lit3   = 0;

    localparam logic [63:0] G_DIAG = 64'h8040201008040201;
    localparam logic [63:0] G_D    = 64'h0123456789ABCDEF;

    life_grid_scanner #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL),
        .FCNT_W       (FW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .grid_in     (grid_in),
        .grid_valid  (grid_valid),
        .grid_ready  (grid_ready),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Behavioural model: scan position is the number of enabled cycles since the
    // frame began; row and phase follow by division.
    bit          m_run = 1'b0;
    int          m_tick = 0;
    logic [63:0] m_act = '0;
    logic [63:0] m_sh = '0;
    bit          m_full = 1'b0;
    int          m_fc = 0;
    int          r, off;
    logic [7:0]  e_rs, e_cd;
    logic        e_fd;
    bit          old_full;

    initial begin
        forever begin
            @(negedge clk);
            e_rs = '0;
            e_cd = '0;
            e_fd = 1'b0;
            if (m_run && enable) begin
                r   = m_tick / ROW_T;
                off = m_tick % ROW_T;
                if (off >= BL) begin
                    e_rs = 8'(1 << r);
                    e_cd = m_act[8*r +: 8];
                end
                e_fd = (m_tick == FRAME_T - 1);
            end
            check("row_sel", row_sel, e_rs);
            check("col_data", col_data, e_cd);
            check("frame_done", frame_done, e_fd);
            check("frame_count", frame_count, m_fc[FW-1:0]);
            check("grid_ready", grid_ready, !m_full && !reset);

            if (reset) begin
                m_run = 0; m_tick = 0; m_act = '0; m_sh = '0; m_full = 0; m_fc = 0;
            end else begin
                old_full = m_full;
                if (!m_run) begin
                    if (m_full) begin
                        m_act = m_sh; m_full = 0; m_run = 1; m_tick = 0;
                    end
                end else if (enable) begin
                    if (m_tick == FRAME_T - 1) begin
                        m_tick = 0;
                        m_fc   = (m_fc + 1) % (1 << FW);
                        if (m_full) begin
                            m_act = m_sh; m_full = 0;
                        end
                    end else begin
                        m_tick++;
                    end
                end
                if (grid_valid && !old_full) begin
                    m_sh = grid_in; m_full = 1;
                end
            end
        end
    end

    // Lit cycles of row 3 around the enable freeze.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 290 && cyc < 320 && row_sel == 8'h08) lit3++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        repeat (50) tick();
        #3;
        check("idle_ready", grid_ready, 1'b1);
        check("idle_rows", row_sel, 8'h00);
        check("idle_fcnt", frame_count, 4'd0);

        // Basic timing
        tick();
        cyc = 0;
        grid_in = G_DIAG; grid_valid = 1'b1;
        go_to(1);  grid_valid = 1'b0;
        go_to(2);  #3; check("blank_c2", row_sel, 8'h00);
        go_to(4);  #3; check("row0_sel", row_sel, 8'h01); check("row0_col", col_data, 8'h01);
        go_to(9);  #3; check("row1_sel", row_sel, 8'h02); check("row1_col", col_data, 8'h02);
        go_to(40); #3; check("fd_c40", frame_done, 1'b0);
        go_to(41); #3; check("fd_c41", frame_done, 1'b1); check("row7_col", col_data, 8'h80);
        go_to(42); #3; check("fcnt_c42", frame_count, 4'd1); check("fd_c42", frame_done, 1'b0);

        // Double buffer: A then B, third grid refused while full
        go_to(43); grid_in = '1; grid_valid = 1'b1;
        go_to(44); grid_valid = 1'b0;
        go_to(50); grid_in = '0; grid_valid = 1'b1;
        #3; check("full_ready", grid_ready, 1'b0); check("old_grid", col_data, 8'h02);
        go_to(82); #3; check("bound_ready", grid_ready, 1'b1);
        go_to(83); grid_valid = 1'b0;
        go_to(84); #3; check("gridA_col", col_data, 8'hFF);
        go_to(90); grid_in = {32{2'b01}}; grid_valid = 1'b1;
        #3; check("third_ready", grid_ready, 1'b0);
        go_to(96); grid_valid = 1'b0;
        go_to(124); #3; check("gridB_sel", row_sel, 8'h01); check("gridB_col", col_data, 8'h00);
        go_to(164); #3; check("no_third", col_data, 8'h00);

        // Accept on the frame boundary cycle
        go_to(201); grid_in = G_D; grid_valid = 1'b1;
        #3; check("bnd_fd", frame_done, 1'b1); check("bnd_ready", grid_ready, 1'b1);
        go_to(202); grid_valid = 1'b0;
        go_to(204); #3; check("bnd_old", col_data, 8'h00);
        go_to(244); #3; check("bnd_new", col_data, 8'hEF);

        // Enable freeze mid-DRIVE of row 3
        go_to(300); enable = 1'b0;
        go_to(305); #3; check("frz_sel", row_sel, 8'h00); check("frz_col", col_data, 8'h00);
        go_to(310); enable = 1'b1;
        #3; check("resume_sel", row_sel, 8'h08); check("resume_col", col_data, 8'h89);
        go_to(312); #3; check("resume_blank", row_sel, 8'h00);
        go_to(314); #3; check("row4_sel", row_sel, 8'h10); check("row4_col", col_data, 8'h67);
        go_to(330); #3; check("row3_lit", lit3, 3);
        go_to(331); #3; check("frz_fd", frame_done, 1'b1);
        go_to(332); #3; check("fcnt8", frame_count, 4'd8);

        // Wrap
        go_to(651); #3; check("fcnt15", frame_count, 4'd15);
        go_to(652); #3; check("fcnt_wrap", frame_count, 4'd0);

        // Reset mid-row 5 with a pending shadow grid
        go_to(660); grid_in = '1; grid_valid = 1'b1;
        go_to(661); grid_valid = 1'b0;
        go_to(680); reset = 1'b1;
        #3; check("rst_ready", grid_ready, 1'b0); check("row5_sel", row_sel, 8'h20);
        go_to(681); reset = 1'b0;
        #3; check("rst_sel", row_sel, 8'h00); check("rst_fcnt", frame_count, 4'd0);
        check("rst_ready1", grid_ready, 1'b1);
        go_to(780); #3; check("no_pending", row_sel, 8'h00); check("no_pending_col", col_data, 8'h00);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
